// File: rtl/mcdt_rr_arbiter.sv
// mcdt_rr_arbiter: shares the MCDT output port among three channel FIFOs.
// One channel is granted per burst (round-robin or fixed priority). Each
// granted word is popped with an ack and forwarded one cycle later, tagged
// with its channel id.
// Ports:
//   clk, rstn            clock, asynchronous active-high reset
//   cfg_en_i, cfg_mode_i arbitration enable, 0=round-robin / 1=fixed priority
//   chN_req_i/data_i     channel N FIFO non-empty flag and head word
//   chN_ack_o            pop strobe to channel N (combinational)
//   mcdt_data/val/id_o   forwarded word, valid flag, source channel
//   busy_o               a burst is in progress
module mcdt_rr_arbiter #(
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cfg_en_i,
    input  logic          cfg_mode_i,
    input  logic          ch0_req_i,
    input  logic [DW-1:0] ch0_data_i,
    input  logic          ch1_req_i,
    input  logic [DW-1:0] ch1_data_i,
    input  logic          ch2_req_i,
    input  logic [DW-1:0] ch2_data_i,
    output logic          ch0_ack_o,
    output logic          ch1_ack_o,
    output logic          ch2_ack_o,
    output logic [DW-1:0] mcdt_data_o,
    output logic          mcdt_val_o,
    output logic [1:0]    mcdt_id_o,
    output logic          busy_o
);

    localparam int unsigned CW = $clog2(BURST_MAX) + 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [2:0]    req;
    logic [1:0]    winner;
    logic [1:0]    start;
    logic [2:0]    cand;
    logic          sel_req;
    logic [DW-1:0] sel_data;
    logic          ack;

    assign req = {ch2_req_i, ch1_req_i, ch0_req_i};

    // Winner selection; the reverse loop lets the closest candidate win.
    always_comb begin
        winner = 2'd0;
        cand   = 3'd0;
        start  = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        if (cfg_mode_i) begin
            if (req[0])      winner = 2'd0;
            else if (req[1]) winner = 2'd1;
            else             winner = 2'd2;
        end else begin
            for (int i = 2; i >= 0; i--) begin
                cand = {1'b0, start} + 3'(i);
                if (cand >= 3'd3) cand = cand - 3'd3;
                if (req[cand[1:0]]) winner = cand[1:0];
            end
        end
    end

    // Request and head word of the granted channel.
    always_comb begin
        case (grant_q)
            2'd0:    begin sel_req = req[0]; sel_data = ch0_data_i; end
            2'd1:    begin sel_req = req[1]; sel_data = ch1_data_i; end
            default: begin sel_req = req[2]; sel_data = ch2_data_i; end
        endcase
    end

    assign ack       = (state_q == XFER) && sel_req;
    assign ch0_ack_o = ack && (grant_q == 2'd0);
    assign ch1_ack_o = ack && (grant_q == 2'd1);
    assign ch2_ack_o = ack && (grant_q == 2'd2);
    assign busy_o    = (state_q == XFER);

    // State register.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            last_q  <= 2'd2;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cfg_en_i && (req != 3'b000)) begin
                    grant_d = winner;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!sel_req) begin
                    // FIFO ran empty: close the burst without an ack.
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (cnt_q == CW'(BURST_MAX - 1)) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: one-cycle latency from ack; id holds while idle.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            mcdt_data_o <= '0;
            mcdt_val_o  <= 1'b0;
            mcdt_id_o   <= 2'd0;
        end else begin
            mcdt_val_o <= ack;
            if (ack) begin
                mcdt_data_o <= sel_data;
                mcdt_id_o   <= grant_q;
            end else begin
                mcdt_data_o <= '0;
            end
        end
    end

endmodule
